// File: rtl/fetch_branch_target_buffer.sv
// fetch_branch_target_buffer
//   Set-associative branch target buffer for the fetch stage. Each entry
//   carries a valid bit, tag, 2-bit direction counter and full target.
//   Replacement is true LRU kept as per-way ages (0 = most recent).
//   Search responses are registered (1-cycle latency). The update path
//   allocates only on taken misses. Saturating counters track lookups,
//   hits and reported mispredicts.
//
// Ports
//   iCLOCK, iRESET (async, active high), iRESET_SYNC, iFLUSH
//   search : iSEARCH_STB, iSEARCH_INST_ADDR ->
//            oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR
//   update : iUPDATE_STB, iUPDATE_TAKEN, iUPDATE_MISPREDICT,
//            iUPDATE_TARGET, iUPDATE_INST_ADDR
//   perf   : oPERF_LOOKUP, oPERF_HIT, oPERF_MISPREDICT
module fetch_branch_target_buffer #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int CNT_W = 32
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             iRESET_SYNC,
    input  logic             iFLUSH,
    input  logic             iSEARCH_STB,
    input  logic [31:0]      iSEARCH_INST_ADDR,
    output logic             oSEARCH_VALID,
    output logic             oSEARCH_HIT,
    output logic             oSEARCH_PREDICT_BRANCH,
    output logic [31:0]      oSEARCH_ADDR,
    input  logic             iUPDATE_STB,
    input  logic             iUPDATE_TAKEN,
    input  logic             iUPDATE_MISPREDICT,
    input  logic [31:0]      iUPDATE_TARGET,
    input  logic [31:0]      iUPDATE_INST_ADDR,
    output logic [CNT_W-1:0] oPERF_LOOKUP,
    output logic [CNT_W-1:0] oPERF_HIT,
    output logic [CNT_W-1:0] oPERF_MISPREDICT
);

    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [AGE_W-1:0] way_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [SETS-1:0][WAYS-1:0]             valid;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag;
    logic [SETS-1:0][WAYS-1:0][1:0]        ctr;
    logic [SETS-1:0][WAYS-1:0][31:0]       target;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age;

    // Low address bits never take part in indexing or tag compare.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iSEARCH_INST_ADDR[1:0], iUPDATE_INST_ADDR[1:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // ---------------- search lookup (reads pre-update state) ----------------
    idx_t        s_idx;
    tag_t        s_tag;
    logic        s_hit;
    logic [1:0]  s_ctr;
    logic [31:0] s_target;

    always_comb begin
        s_idx    = iSEARCH_INST_ADDR[IDX_W+1:2];
        s_tag    = iSEARCH_INST_ADDR[31:IDX_W+2];
        s_hit    = 1'b0;
        s_ctr    = 2'd0;
        s_target = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[s_idx][w] && tag[s_idx][w] == s_tag) begin
                s_hit    = 1'b1;
                s_ctr    = ctr[s_idx][w];
                s_target = target[s_idx][w];
            end
        end
    end

    // ---------------- update: way select, counter, LRU ----------------
    idx_t                       u_idx;
    tag_t                       u_tag;
    logic                       u_hit;
    way_t                       u_way;
    logic                       inv_found;
    way_t                       inv_way;
    way_t                       lru_way;
    way_t                       sel_way;
    logic                       u_write;
    logic [1:0]                 new_ctr;
    logic [WAYS-1:0][AGE_W-1:0] new_age;

    always_comb begin
        u_idx     = iUPDATE_INST_ADDR[IDX_W+1:2];
        u_tag     = iUPDATE_INST_ADDR[31:IDX_W+2];
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[u_idx][w] && tag[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = way_t'(w);
            end
            // First invalid way wins, so the lowest index is the victim.
            if (!valid[u_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = way_t'(w);
            end
            if (age[u_idx][w] == way_t'(WAYS - 1))
                lru_way = way_t'(w);
        end

        sel_way = u_hit ? u_way : (inv_found ? inv_way : lru_way);
        u_write = iUPDATE_STB && (u_hit || iUPDATE_TAKEN);

        if (!u_hit)
            new_ctr = 2'd2;
        else if (iUPDATE_TAKEN)
            new_ctr = (ctr[u_idx][sel_way] == 2'd3) ? 2'd3 : ctr[u_idx][sel_way] + 2'd1;
        else
            new_ctr = (ctr[u_idx][sel_way] == 2'd0) ? 2'd0 : ctr[u_idx][sel_way] - 2'd1;

        // Touch: ways younger than the selected one age by one, it becomes 0.
        for (int w = 0; w < WAYS; w++) begin
            if (way_t'(w) == sel_way)
                new_age[w] = '0;
            else if (age[u_idx][w] < age[u_idx][sel_way])
                new_age[w] = age[u_idx][w] + 1'b1;
            else
                new_age[w] = age[u_idx][w];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            valid  <= '0;
            tag    <= '0;
            ctr    <= '0;
            target <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= way_t'(w);
            oSEARCH_VALID          <= 1'b0;
            oSEARCH_HIT            <= 1'b0;
            oSEARCH_PREDICT_BRANCH <= 1'b0;
            oSEARCH_ADDR           <= '0;
            oPERF_LOOKUP           <= '0;
            oPERF_HIT              <= '0;
            oPERF_MISPREDICT       <= '0;
        end else if (iRESET_SYNC || iFLUSH) begin
            // Coincident search and update are dropped; response fields hold.
            valid <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= way_t'(w);
            oSEARCH_VALID <= 1'b0;
            if (iRESET_SYNC) begin
                oPERF_LOOKUP     <= '0;
                oPERF_HIT        <= '0;
                oPERF_MISPREDICT <= '0;
            end
        end else begin
            oSEARCH_VALID <= iSEARCH_STB;
            if (iSEARCH_STB) begin
                oSEARCH_HIT            <= s_hit;
                oSEARCH_PREDICT_BRANCH <= s_hit && s_ctr[1];
                oSEARCH_ADDR           <= s_target;
                oPERF_LOOKUP           <= sat_inc(oPERF_LOOKUP);
                if (s_hit)
                    oPERF_HIT <= sat_inc(oPERF_HIT);
            end
            if (iUPDATE_STB && iUPDATE_MISPREDICT)
                oPERF_MISPREDICT <= sat_inc(oPERF_MISPREDICT);
            if (u_write) begin
                valid[u_idx][sel_way] <= 1'b1;
                tag[u_idx][sel_way]   <= u_tag;
                ctr[u_idx][sel_way]   <= new_ctr;
                if (iUPDATE_TAKEN)
                    target[u_idx][sel_way] <= iUPDATE_TARGET;
                age[u_idx] <= new_age;
            end
        end
    end

endmodule

// File: tb/tb_fetch_branch_target_buffer.sv
// Bench for fetch_branch_target_buffer: directed scenarios followed by
// random traffic, all compared against a recency-list reference model.
// Two instances share inputs: CNT_W=32 and CNT_W=4 (counter saturation).
module tb_fetch_branch_target_buffer;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int IDX_W = $clog2(SETS);

    logic        iCLOCK = 1'b0;
    logic        iRESET, iRESET_SYNC, iFLUSH;
    logic        iSEARCH_STB;
    logic [31:0] iSEARCH_INST_ADDR;
    logic        iUPDATE_STB, iUPDATE_TAKEN, iUPDATE_MISPREDICT;
    logic [31:0] iUPDATE_TARGET, iUPDATE_INST_ADDR;

    logic        oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH;
    logic [31:0] oSEARCH_ADDR;
    logic [31:0] oPERF_LOOKUP, oPERF_HIT, oPERF_MISPREDICT;

    logic        sat_valid, sat_hit, sat_pred;
    logic [31:0] sat_addr;
    logic [3:0]  sat_lookup, sat_hitcnt, sat_mis;

    always #5 iCLOCK = ~iCLOCK;

    fetch_branch_target_buffer #(.SETS(SETS), .WAYS(WAYS), .CNT_W(32)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
        .iSEARCH_STB(iSEARCH_STB), .iSEARCH_INST_ADDR(iSEARCH_INST_ADDR),
        .oSEARCH_VALID(oSEARCH_VALID), .oSEARCH_HIT(oSEARCH_HIT),
        .oSEARCH_PREDICT_BRANCH(oSEARCH_PREDICT_BRANCH), .oSEARCH_ADDR(oSEARCH_ADDR),
        .iUPDATE_STB(iUPDATE_STB), .iUPDATE_TAKEN(iUPDATE_TAKEN),
        .iUPDATE_MISPREDICT(iUPDATE_MISPREDICT), .iUPDATE_TARGET(iUPDATE_TARGET),
        .iUPDATE_INST_ADDR(iUPDATE_INST_ADDR),
        .oPERF_LOOKUP(oPERF_LOOKUP), .oPERF_HIT(oPERF_HIT), .oPERF_MISPREDICT(oPERF_MISPREDICT)
    );

    fetch_branch_target_buffer #(.SETS(SETS), .WAYS(WAYS), .CNT_W(4)) dut_sat (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
        .iSEARCH_STB(iSEARCH_STB), .iSEARCH_INST_ADDR(iSEARCH_INST_ADDR),
        .oSEARCH_VALID(sat_valid), .oSEARCH_HIT(sat_hit),
        .oSEARCH_PREDICT_BRANCH(sat_pred), .oSEARCH_ADDR(sat_addr),
        .iUPDATE_STB(iUPDATE_STB), .iUPDATE_TAKEN(iUPDATE_TAKEN),
        .iUPDATE_MISPREDICT(iUPDATE_MISPREDICT), .iUPDATE_TARGET(iUPDATE_TARGET),
        .iUPDATE_INST_ADDR(iUPDATE_INST_ADDR),
        .oPERF_LOOKUP(sat_lookup), .oPERF_HIT(sat_hitcnt), .oPERF_MISPREDICT(sat_mis)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Recency kept as an ordered list per set: m_order[s][0] is most recent.
    bit          m_valid[SETS][WAYS];
    logic [31:0] m_tag[SETS][WAYS];
    int          m_ctr[SETS][WAYS];
    logic [31:0] m_tgt[SETS][WAYS];
    int          m_order[SETS][WAYS];
    int          c_lookup, c_hit, c_mis;
    bit          e_valid, e_hit, e_pred;
    logic [31:0] e_addr;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (IDX_W + 2);
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
        return -1;
    endfunction

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    task automatic m_init(input bit clr_cnt);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_order[s][w] = w;
            end
        if (clr_cnt) begin
            c_lookup = 0; c_hit = 0; c_mis = 0;
        end
    endtask

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic m_step();
        int s, w;
        if (iRESET_SYNC) begin
            m_init(1); e_valid = 0; return;
        end
        if (iFLUSH) begin
            m_init(0); e_valid = 0; return;
        end
        e_valid = iSEARCH_STB;
        if (iSEARCH_STB) begin
            s = set_of(iSEARCH_INST_ADDR);
            w = m_find(iSEARCH_INST_ADDR);
            e_hit  = (w >= 0);
            e_pred = e_hit && m_ctr[s][w] >= 2;
            e_addr = e_hit ? m_tgt[s][w] : 32'd0;
            c_lookup++;
            if (e_hit) c_hit++;
        end
        if (iUPDATE_STB) begin
            if (iUPDATE_MISPREDICT) c_mis++;
            s = set_of(iUPDATE_INST_ADDR);
            w = m_find(iUPDATE_INST_ADDR);
            if (w >= 0) begin
                if (iUPDATE_TAKEN) begin
                    if (m_ctr[s][w] < 3) m_ctr[s][w]++;
                    m_tgt[s][w] = iUPDATE_TARGET;
                end else if (m_ctr[s][w] > 0) begin
                    m_ctr[s][w]--;
                end
                m_touch(s, w);
            end else if (iUPDATE_TAKEN) begin
                w = m_order[s][WAYS-1];
                for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
                m_valid[s][w] = 1;
                m_tag[s][w]   = tag_of(iUPDATE_INST_ADDR);
                m_ctr[s][w]   = 2;
                m_tgt[s][w]   = iUPDATE_TARGET;
                m_touch(s, w);
            end
        end
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic idle();
        iSEARCH_STB = 0; iSEARCH_INST_ADDR = '0;
        iUPDATE_STB = 0; iUPDATE_TAKEN = 0; iUPDATE_MISPREDICT = 0;
        iUPDATE_TARGET = '0; iUPDATE_INST_ADDR = '0;
        iFLUSH = 0; iRESET_SYNC = 0;
    endtask

    task automatic set_search(input logic [31:0] a);
        iSEARCH_STB = 1; iSEARCH_INST_ADDR = a;
    endtask

    task automatic set_update(input logic [31:0] a, input bit tk, input logic [31:0] t, input bit mp);
        iUPDATE_STB = 1; iUPDATE_INST_ADDR = a; iUPDATE_TAKEN = tk;
        iUPDATE_TARGET = t; iUPDATE_MISPREDICT = mp;
    endtask

    task automatic check_all();
        chk("valid", 64'(oSEARCH_VALID), 64'(e_valid));
        chk("sat_valid", 64'(sat_valid), 64'(e_valid));
        if (e_valid) begin
            chk("hit", 64'(oSEARCH_HIT), 64'(e_hit));
            chk("predict", 64'(oSEARCH_PREDICT_BRANCH), 64'(e_pred));
            chk("addr", 64'(oSEARCH_ADDR), 64'(e_addr));
            chk("sat_hit", 64'(sat_hit), 64'(e_hit));
        end
        chk("perf_lookup", 64'(oPERF_LOOKUP), 64'(c_lookup));
        chk("perf_hit", 64'(oPERF_HIT), 64'(c_hit));
        chk("perf_mis", 64'(oPERF_MISPREDICT), 64'(c_mis));
        chk("sat_lookup", 64'(sat_lookup), 64'(sat4(c_lookup)));
        chk("sat_hitcnt", 64'(sat_hitcnt), 64'(sat4(c_hit)));
        chk("sat_mis", 64'(sat_mis), 64'(sat4(c_mis)));
    endtask

    task automatic tick();
        m_step();
        @(posedge iCLOCK);
        #1;
        check_all();
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [31:0] a;
        idle();
        iRESET = 1;
        m_init(1);
        e_valid = 0; e_hit = 0; e_pred = 0; e_addr = '0;
        #12;
        chk("rst_valid", 64'(oSEARCH_VALID), 0);
        chk("rst_hit", 64'(oSEARCH_HIT), 0);
        chk("rst_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
        chk("rst_addr", 64'(oSEARCH_ADDR), 0);
        chk("rst_lookup", 64'(oPERF_LOOKUP), 0);
        @(negedge iCLOCK) iRESET = 0;
        @(posedge iCLOCK); #1;

        // cold miss
        set_search(32'h100); tick(); idle();
        chk("t1_valid", 64'(oSEARCH_VALID), 1);
        chk("t1_hit", 64'(oSEARCH_HIT), 0);
        chk("t1_addr", 64'(oSEARCH_ADDR), 0);
        chk("t1_lookup", 64'(oPERF_LOOKUP), 1);
        chk("t1_hitcnt", 64'(oPERF_HIT), 0);

        // allocate, then train down
        set_update(32'h100, 1, 32'h2000, 0); tick(); idle();
        set_search(32'h100); tick(); idle();
        chk("t2_hit", 64'(oSEARCH_HIT), 1);
        chk("t2_pred", 64'(oSEARCH_PREDICT_BRANCH), 1);
        chk("t2_addr", 64'(oSEARCH_ADDR), 32'h2000);
        set_update(32'h100, 0, 32'hdead, 0); tick(); tick(); idle();
        set_search(32'h100); tick(); idle();
        chk("t3_hit", 64'(oSEARCH_HIT), 1);
        chk("t3_pred", 64'(oSEARCH_PREDICT_BRANCH), 0);
        chk("t3_addr", 64'(oSEARCH_ADDR), 32'h2000);

        // read-before-write: ctr 0->1 then 1->2 with coincident searches
        set_search(32'h100); set_update(32'h100, 1, 32'h2000, 0);
        tick(); chk("rbw_pred0", 64'(oSEARCH_PREDICT_BRANCH), 0);
        tick(); chk("rbw_pred1", 64'(oSEARCH_PREDICT_BRANCH), 0);
        idle(); set_search(32'h100);
        tick(); chk("rbw_pred2", 64'(oSEARCH_PREDICT_BRANCH), 1);
        idle();

        // not-taken miss does not allocate
        set_update(32'h180, 0, 32'h4000, 0); tick(); idle();
        set_search(32'h180); tick(); idle();
        chk("nt_noalloc", 64'(oSEARCH_HIT), 0);

        // LRU
        iFLUSH = 1; tick(); idle();
        set_update(32'h100, 1, 32'h1111, 0); tick();
        set_update(32'h200, 1, 32'h2222, 0); tick();
        set_update(32'h100, 1, 32'h1111, 0); tick();
        set_update(32'h300, 1, 32'h3333, 0); tick(); idle();
        set_search(32'h100); tick(); chk("lru_100", 64'(oSEARCH_HIT), 1);
        set_search(32'h200); tick(); chk("lru_200", 64'(oSEARCH_HIT), 0);
        set_search(32'h300); tick(); chk("lru_300", 64'(oSEARCH_HIT), 1);
        chk("lru_300_addr", 64'(oSEARCH_ADDR), 32'h3333);
        idle();

        // flush
        set_search(32'h100); iFLUSH = 1; tick(); idle();
        chk("flush_valid", 64'(oSEARCH_VALID), 0);
        tick();
        set_search(32'h100); tick(); idle();
        chk("flush_hit", 64'(oSEARCH_HIT), 0);
        iRESET_SYNC = 1; tick(); idle();
        chk("rsync_lookup", 64'(oPERF_LOOKUP), 0);
        chk("rsync_hit", 64'(oPERF_HIT), 0);
        chk("rsync_mis", 64'(oPERF_MISPREDICT), 0);
        set_update(32'h100, 1, 32'h5555, 1); iFLUSH = 1; tick(); idle();
        chk("flush_upd_mis", 64'(oPERF_MISPREDICT), 0);

        // saturation
        for (int i = 0; i < 17; i++) begin
            set_search(32'h1000 + 32'(i) * 4); tick();
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            set_update(32'h8000 + 32'(i) * 4, 0, 32'h0, 1); tick();
        end
        idle(); tick();
        chk("sat_lookup15", 64'(sat_lookup), 15);
        chk("sat_mis15", 64'(sat_mis), 15);
        chk("full_lookup17", 64'(oPERF_LOOKUP), 17);
        chk("full_mis20", 64'(oPERF_MISPREDICT), 20);

        // async reset drops an in-flight response at once
        set_search(32'h100); tick(); idle();
        #2 iRESET = 1;
        #1;
        chk("arst_valid", 64'(oSEARCH_VALID), 0);
        chk("arst_lookup", 64'(oPERF_LOOKUP), 0);
        m_init(1);
        e_valid = 0; e_hit = 0; e_pred = 0; e_addr = '0;
        @(negedge iCLOCK) iRESET = 0;
        @(posedge iCLOCK); #1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                a = (32'($urandom_range(0, 3)) << (IDX_W + 2)) |
                    (32'($urandom_range(0, SETS - 1)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) a = a ^ 32'h8000_0000;
                set_search(a);
            end
            if ($urandom_range(0, 2) != 0) begin
                a = (32'($urandom_range(0, 3)) << (IDX_W + 2)) |
                    (32'($urandom_range(0, SETS - 1)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) a = a ^ 32'h8000_0000;
                set_update(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            end
            iFLUSH      = ($urandom_range(0, 49) == 0);
            iRESET_SYNC = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
